// File: rtl/bin_string_rx.sv
// bin_string_rx: serial MSB-first receiver that packs characters into a
// fixed-width string, ending a frame on NUL or when every slot is filled.
module bin_string_rx #(
    parameter int NCHARS = 64,
    parameter int CHAR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     ack,
    output logic [NCHARS*CHAR_W-1:0] str,
    output logic                     string_valid,
    output logic                     busy,
    output logic [6:0]               char_count,
    output logic                     overrun
);

    localparam int L  = NCHARS * CHAR_W;
    localparam int CW = $clog2(CHAR_W);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [L-1:0]        str_n;
    logic [6:0]          cc_n;
    logic [CW-1:0]       bit_cnt, bit_cnt_n;
    logic [CHAR_W-1:0]   shreg, shreg_n;
    logic [CHAR_W-1:0]   byte_next;
    logic                ovr_n;
    logic                last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            str        <= '0;
            char_count <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            str        <= str_n;
            char_count <= cc_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            overrun    <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        str_n     = str;
        cc_n      = char_count;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ovr_n     = overrun;
        byte_next = {shreg[CHAR_W-2:0], bit_in};
        last_bit  = (bit_cnt == CW'(CHAR_W - 1));

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = RECV;
                    str_n     = '0;
                    cc_n      = '0;
                    bit_cnt_n = '0;
                    shreg_n   = '0;
                    ovr_n     = 1'b0;
                end
            end
            RECV: begin
                if (start) begin
                    str_n     = '0;
                    cc_n      = '0;
                    bit_cnt_n = '0;
                    shreg_n   = '0;
                    ovr_n     = 1'b0;
                end else if (bit_valid) begin
                    shreg_n   = byte_next;
                    bit_cnt_n = bit_cnt + CW'(1);
                    if (last_bit) begin
                        bit_cnt_n = '0;
                        shreg_n   = '0;
                        // NUL closes the frame without consuming a slot
                        if (byte_next == '0) begin
                            state_n = DONE;
                        end else begin
                            for (int k = 0; k < NCHARS; k++) begin
                                if (char_count == 7'(k))
                                    str_n[L-1-CHAR_W*k -: CHAR_W] = byte_next;
                            end
                            cc_n = char_count + 7'd1;
                            if (cc_n == 7'(NCHARS))
                                state_n = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (bit_valid)
                    ovr_n = 1'b1;
                if (ack)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy         = (state == RECV);
    assign string_valid = (state == DONE);

endmodule

// File: tb/tb_bin_string_rx.sv
// tb_bin_string_rx: directed and randomized frames checked against a
// byte-level reference model of the string packing rules.
module tb_bin_string_rx;

    localparam int N = 64;
    localparam int W = 8;
    localparam int L = N * W;

    logic         clk = 1'b0;
    logic         rst, start, bit_in, bit_valid, ack;
    logic [L-1:0] str;
    logic         string_valid, busy, overrun;
    logic [6:0]   char_count;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]   q[$];
    logic [L-1:0] exp_str;
    int           exp_cnt, used;

    bin_string_rx #(.NCHARS(N), .CHAR_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .ack          (ack),
        .str          (str),
        .string_valid (string_valid),
        .busy         (busy),
        .char_count   (char_count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [L-1:0] obs,
                       input logic [L-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame content implied by a byte stream: stops at NUL or a full string
    function automatic logic [L-1:0] model(input logic [7:0] b[$],
                                           output int cnt, output int nused);
        logic [L-1:0] s;
        s     = '0;
        cnt   = 0;
        nused = 0;
        foreach (b[i]) begin
            nused++;
            if (b[i] == 8'h00) break;
            s[L-1-8*cnt -: 8] = b[i];
            cnt++;
            if (cnt == N) break;
        end
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        for (int i = 7; i >= 0; i--) begin
            repeat ($urandom_range(gapmax, 0)) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                tick();
            end
            bit_valid = 1'b1;
            bit_in    = b[i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_q(input int nb, input int gapmax);
        for (int i = 0; i < nb; i++) send_byte(q[i], gapmax);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".str"}, str, '0);
        chk({tag, ".valid"}, L'(string_valid), '0);
        chk({tag, ".busy"}, L'(busy), '0);
        chk({tag, ".cnt"}, L'(char_count), '0);
        chk({tag, ".ovr"}, L'(overrun), '0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".valid"}, L'(string_valid), L'(1));
        chk({tag, ".busy"}, L'(busy), '0);
        chk({tag, ".cnt"}, L'(char_count), L'(exp_cnt));
        chk({tag, ".str"}, str, exp_str);
    endtask

    task automatic make_az();
        q = {};
        for (int i = 0; i < N; i++) q.push_back(8'h41 + 8'(i % 26));
        exp_str = model(q, exp_cnt, used);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_in = 1'b0;
        bit_valid = 1'b0; ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_vals("reset");

        send_bits(5);
        chk("idle_bits.ovr", L'(overrun), '0);
        chk("idle_bits.busy", L'(busy), '0);

        // Full A..Z frame; bit sent alongside start must be dropped
        make_az();
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0;
        chk("full.busy0", L'(busy), L'(1));
        send_q(N - 1, 0);
        chk("full.pre_valid", L'(string_valid), '0);
        chk("full.pre_busy", L'(busy), L'(1));
        chk("full.pre_cnt", L'(char_count), L'(N - 1));
        send_byte(q[N-1], 0);
        chk_done("full");
        chk("full.top", L'(str[511:504]), L'(8'h41));

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold.str", str, exp_str);
        end
        do_start();
        chk("done_start.str", str, exp_str);
        chk("done_start.valid", L'(string_valid), L'(1));

        bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("ovr.set", L'(overrun), L'(1));
        chk("ovr.str", str, exp_str);
        do_ack();
        chk("ack.valid", L'(string_valid), '0);
        chk("ack.busy", L'(busy), '0);
        chk("ack.str", str, exp_str);
        chk("ack.cnt", L'(char_count), L'(N));
        chk("ack.ovr", L'(overrun), L'(1));
        do_start();
        chk("restart.ovr", L'(overrun), '0);
        chk("restart.str", str, '0);
        chk("restart.cnt", L'(char_count), '0);

        make_az();
        send_q(N, 3);
        chk_done("gapped");
        do_ack();

        q = {8'h48, 8'h69, 8'h00};
        exp_str = model(q, exp_cnt, used);
        do_start();
        send_q(used, 2);
        chk_done("nul");
        chk("nul.hi", L'(str[511:496]), L'(16'h4869));
        chk("nul.low", L'(str[495:0]), '0);
        do_ack();

        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(70, 1);
            q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(30, 0) == 0) q.push_back(8'h00);
                else q.push_back(8'($urandom_range(255, 1)));
            end
            q.push_back(8'h00);
            exp_str = model(q, exp_cnt, used);
            do_start();
            send_q(used, f % 3);
            chk_done("rand");
            do_ack();
        end

        q = {8'h4F, 8'h4B, 8'h00};
        exp_str = model(q, exp_cnt, used);
        do_start();
        send_bits(100);
        do_start();
        chk("abort.cnt", L'(char_count), '0);
        chk("abort.str", str, '0);
        send_q(used, 1);
        chk_done("abort");
        chk("abort.ok", L'(str[511:496]), L'(16'h4F4B));
        do_ack();

        do_start();
        send_bits(300);
        rst = 1'b1; start = 1'b1; bit_valid = 1'b1; ack = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0; ack = 1'b0;
        chk_reset_vals("rst_mid");
        make_az();
        do_start();
        send_q(N, 1);
        chk_done("after_rst");

        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        rst = 1'b1; ack = 1'b1;
        tick();
        rst = 1'b0; ack = 1'b0;
        chk_reset_vals("rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bin_string_rx.md
BIN_STRING_RX -- requirements
Module: bin_string_rx

Interface
REQ-001 The block SHALL have parameter NCHARS, default 64, giving the number of characters per frame.
REQ-002 The block SHALL have parameter CHAR_W, default 8, giving the bits per character.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a new frame.
REQ-006 The block SHALL have port bit_in, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port bit_valid, input, 1 bit: bit_in is valid this cycle.
REQ-008 The block SHALL have port ack, input, 1 bit: consumer has taken the string.
REQ-009 The block SHALL have port string, output, NCHARS*CHAR_W bits: the assembled character string.
REQ-010 The block SHALL have port string_valid, output, 1 bit: string is complete and stable.
REQ-011 The block SHALL have port busy, output, 1 bit: a frame is being received.
REQ-012 The block SHALL have port char_count, output, 7 bits: number of characters stored in the current frame.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag, a bit arrived while the string was pending.

Function
REQ-014 The block SHALL implement states IDLE, RECV and DONE; busy=1 only in RECV, and string_valid=1 only in DONE.
REQ-015 In IDLE or RECV, start SHALL clear string to all zeros, char_count, the bit counter, the shift register and overrun, and SHALL enter RECV the next cycle.
REQ-016 A bit_valid asserted in the same cycle as start SHALL be ignored.
REQ-017 In RECV, each cycle with bit_valid=1 SHALL shift bit_in into an 8-bit shift register MSB-first and increment a 3-bit bit counter.
REQ-018 Cycles with bit_valid=0 SHALL hold all state.
REQ-019 On the CHAR_W-th bit of a character, the completed byte SHALL be written to slot char_count, where slot k occupies string[NCHARS*CHAR_W-1-8k -: 8]; char 0 is therefore the MSB byte.
REQ-020 On that same CHAR_W-th bit, char_count SHALL increment and the bit counter SHALL wrap to 0.
REQ-021 A completed byte equal to 8'h00 (NUL) SHALL terminate the frame: it is not stored, char_count is not incremented, remaining slots stay 8'h00, and the state becomes DONE.
REQ-022 When char_count reaches NCHARS, the state SHALL become DONE.
REQ-023 string_valid SHALL assert the cycle after the last accepted bit (latency 1 clk).
REQ-024 In DONE, string and char_count SHALL be held stable until ack.
REQ-025 In DONE, ack=1 SHALL return the state to IDLE the next cycle; string and char_count keep their values until the next start.
REQ-026 In DONE, start SHALL be ignored.
REQ-027 In DONE, bit_valid=1 SHALL set overrun, and the bit SHALL be discarded.
REQ-028 overrun SHALL stay set until the next accepted start or rst.
REQ-029 In IDLE, bit_valid SHALL be ignored and SHALL NOT set overrun.
REQ-030 start in RECV SHALL abort the frame and restart it per REQ-015; the partial data is discarded.
REQ-031 A partial character pending when a frame ends SHALL be discarded.

Reset
REQ-032 With rst=1, the next clk SHALL force: state IDLE, string all zeros, string_valid=0, busy=0, char_count=0, overrun=0, and the bit counter and shift register to 0.
REQ-033 rst SHALL take priority over start, bit_valid and ack in every state, including mid-frame and in DONE.

Verification
REQ-034 Full frame: start, then 512 bits encoding "A".."Z" cyclically, MSB-first, with no gaps -> string_valid rises 1 clk after bit 512; string[511:504]=8'h41; char_count=64; busy falls in the same cycle.
REQ-035 NUL termination: start, then "Hi" followed by 8'h00 -> DONE with char_count=2; string[511:496]=16'h4869; all lower bits zero.
REQ-036 Gapped input: bit_valid toggling every cycle with random idle gaps -> same string as the gap-free case; hold ack=0 for 10 cycles -> string stable throughout.
REQ-037 Overrun: in DONE, pulse bit_valid once -> overrun=1 and string unchanged; ack then start -> overrun=0.
REQ-038 Abort and restart: start, 100 bits, start again, then the "OK",NUL sequence -> char_count=2, string[511:496]=16'h4F4B.
REQ-039 Reset mid-frame: rst after 300 bits -> all outputs at their reset values next cycle; a following full frame completes correctly.
